// File: rtl/dota_seq.sv
// Sequencer for the comparator-based OTA cell. It runs a SAR offset-trim search with the inputs shorted,
// then duty-cycles the OTA and reports the ones-density of the comparator decisions per window.
module dota_seq #(
  parameter int TRIM_W     = 4,
  parameter int SETTLE_CYC = 8,
  parameter int PERIOD     = 64,
  parameter int WIN        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   cal_start,
  input  logic                   run_en,
  input  logic                   ota_cmp,
  output logic                   ota_en,
  output logic                   ota_short,
  output logic [TRIM_W-1:0]      trim,
  output logic                   busy,
  output logic                   cal_done,
  output logic                   res_valid,
  output logic [$clog2(WIN):0]   res_count,
  output logic [2:0]             dbg_state
);

  localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam int CNT_W = $clog2(PERIOD + 1);
  localparam int SMP_W = $clog2(WIN);
  localparam int RES_W = SMP_W + 1;

  localparam logic [TRIM_W-1:0] TRIM_MID  = TRIM_W'(1) << (TRIM_W - 1);
  localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(TRIM_W - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SLEEP_LD  = CNT_W'(PERIOD - SETTLE_CYC - 2);
  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(WIN - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CAL_SETTLE = 3'd1;
  localparam logic [2:0] S_CAL_DECIDE = 3'd2;
  localparam logic [2:0] S_RUN_WAKE   = 3'd3;
  localparam logic [2:0] S_RUN_SAMPLE = 3'd4;
  localparam logic [2:0] S_RUN_SLEEP  = 3'd5;

  logic [2:0]        state;
  logic              cmp_meta;
  logic              cmp_s;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [SMP_W-1:0]  samp_idx;
  logic [RES_W-1:0]  acc;
  logic [RES_W-1:0]  acc_inc;
  logic              cal_pend;
  logic              in_run;

  assign dbg_state = state;
  assign acc_inc   = acc + RES_W'(cmp_s);
  assign in_run    = (state == S_RUN_WAKE) || (state == S_RUN_SAMPLE) || (state == S_RUN_SLEEP);

  // The comparator output is asynchronous to clk; only cmp_s is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= ota_cmp;
      cmp_s    <= cmp_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ota_en    <= 1'b0;
      ota_short <= 1'b0;
      trim      <= TRIM_MID;
      busy      <= 1'b0;
      cal_done  <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      samp_idx  <= '0;
      acc       <= '0;
      cal_pend  <= 1'b0;
    end else begin
      cal_done  <= 1'b0;
      res_valid <= 1'b0;
      if (!ena) begin
        // Tile disabled: park in IDLE but keep the trim and last result.
        state     <= S_IDLE;
        ota_en    <= 1'b0;
        ota_short <= 1'b0;
        busy      <= 1'b0;
        cnt       <= '0;
        samp_idx  <= '0;
        acc       <= '0;
        cal_pend  <= 1'b0;
      end else begin
        if (cal_start && in_run) begin
          cal_pend <= 1'b1;
        end
        case (state)
          S_IDLE: begin
            if (cal_start || cal_pend) begin
              state     <= S_CAL_SETTLE;
              trim      <= TRIM_MID;
              bit_idx   <= IDX_TOP;
              ota_en    <= 1'b1;
              ota_short <= 1'b1;
              cal_pend  <= 1'b0;
              cnt       <= SETTLE_LD;
              busy      <= 1'b1;
            end else if (run_en) begin
              state  <= S_RUN_WAKE;
              ota_en <= 1'b1;
              cnt    <= SETTLE_LD;
              busy   <= 1'b1;
            end
          end
          S_CAL_SETTLE: begin
            if (cnt == '0) begin
              state <= S_CAL_DECIDE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_CAL_DECIDE: begin
            // A high decision means the trial trim overshoots: drop this bit.
            if (cmp_s) begin
              trim[bit_idx] <= 1'b0;
            end
            if (bit_idx != '0) begin
              trim[bit_idx - IDX_W'(1)] <= 1'b1;
              bit_idx <= bit_idx - IDX_W'(1);
              cnt     <= SETTLE_LD;
              state   <= S_CAL_SETTLE;
            end else begin
              ota_en    <= 1'b0;
              ota_short <= 1'b0;
              cal_done  <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
          S_RUN_WAKE: begin
            if (cnt == '0) begin
              state <= S_RUN_SAMPLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_RUN_SAMPLE: begin
            ota_en <= 1'b0;
            cnt    <= SLEEP_LD;
            state  <= S_RUN_SLEEP;
            if (samp_idx == SMP_LAST) begin
              res_count <= acc_inc;
              res_valid <= 1'b1;
              acc       <= '0;
              samp_idx  <= '0;
            end else begin
              acc      <= acc_inc;
              samp_idx <= samp_idx + SMP_W'(1);
            end
          end
          S_RUN_SLEEP: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (cal_pend || !run_en) begin
              // A partial window is discarded rather than reported.
              state    <= S_IDLE;
              busy     <= 1'b0;
              acc      <= '0;
              samp_idx <= '0;
            end else begin
              state  <= S_RUN_WAKE;
              ota_en <= 1'b1;
              cnt    <= SETTLE_LD;
            end
          end
          default: begin
            state     <= S_IDLE;
            ota_en    <= 1'b0;
            ota_short <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dota_seq.sv
// Directed bench for dota_seq: calibration search, duty-cycled sampling, window results,
// calibration requests during RUN, run stop, tile disable and asynchronous reset.
module tb_dota_seq;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       cal_start;
  logic       run_en;
  logic       ota_cmp;
  logic       ota_en;
  logic       ota_short;
  logic [3:0] trim;
  logic       busy;
  logic       cal_done;
  logic       res_valid;
  logic [4:0] res_count;
  logic [2:0] dbg_state;

  logic       cmp_drv;
  logic       model_on;
  int         checks;
  int         errors;
  int         cyc;
  int         s1;
  int         e1;
  logic [4:0] exp_q[$];
  int         rv_cyc[$];
  logic [3:0] trim_log[$];

  // Comparator model: the offset is cancelled once trim reaches 11.
  assign ota_cmp = model_on ? (trim >= 4'd11) : cmp_drv;

  dota_seq #(.TRIM_W(4), .SETTLE_CYC(8), .PERIOD(64), .WIN(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cal_start (cal_start),
    .run_en    (run_en),
    .ota_cmp   (ota_cmp),
    .ota_en    (ota_en),
    .ota_short (ota_short),
    .trim      (trim),
    .busy      (busy),
    .cal_done  (cal_done),
    .res_valid (res_valid),
    .res_count (res_count),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every res_valid must match the next expected window count.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      rv_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("res_unexp", 32'(res_valid), 0);
      else check("res_count", 32'(res_count), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_rv(input int n, input int budget);
    int k;
    k = 0;
    while (rv_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    check("rv_wait", rv_cyc.size(), n);
  endtask

  // Pulses cal_start and returns the cycle of cal_done, counting the cycle after the sampling edge as 1.
  task automatic run_cal(output int done_at);
    int c0;
    int n;
    logic [3:0] last;
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    c0 = cyc;
    s1 = int'(ota_short);
    e1 = int'(ota_en);
    trim_log.delete();
    trim_log.push_back(trim);
    last = trim;
    n = 0;
    while (!cal_done && n < 100) begin
      step();
      n++;
      if (trim != last) begin
        trim_log.push_back(trim);
        last = trim;
      end
    end
    done_at = cal_done ? (cyc - c0 + 1) : 0;
  endtask

  initial begin
    int done_at;
    int hi;
    int k;
    int t0;
    int y;
    int z;
    int c0;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    cal_start = 1'b0;
    run_en    = 1'b0;
    cmp_drv   = 1'b0;
    model_on  = 1'b0;

    // Reset values
    #23;
    check("rst_ota_en", ota_en, 0);
    check("rst_short", ota_short, 0);
    check("rst_trim", trim, 8);
    check("rst_busy", busy, 0);
    check("rst_cal_done", cal_done, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_count", res_count, 0);
    rst_n = 1'b1;
    step();
    step();

    // Calibration with cmp stuck low
    run_cal(done_at);
    check("cal0_short_c1", s1, 1);
    check("cal0_en_c1", e1, 1);
    check("cal0_done_cyc", done_at, 37);
    check("cal0_trim", trim, 15);
    check("cal0_short_end", ota_short, 0);
    check("cal0_en_end", ota_en, 0);
    check("cal0_busy_end", busy, 0);
    step();
    check("cal0_done_pulse", cal_done, 0);

    // Calibration with cmp stuck high, then against the offset model
    cmp_drv = 1'b1;
    run_cal(done_at);
    check("cal1_done_cyc", done_at, 37);
    check("cal1_trim", trim, 0);
    step();
    model_on = 1'b1;
    run_cal(done_at);
    check("calm_done_cyc", done_at, 37);
    check("calm_log_len", trim_log.size(), 5);
    if (trim_log.size() == 5) begin
      check("calm_t0", trim_log[0], 8);
      check("calm_t1", trim_log[1], 12);
      check("calm_t2", trim_log[2], 10);
      check("calm_t3", trim_log[3], 11);
    end
    check("calm_trim", trim, 10);
    model_on = 1'b0;
    step();

    // RUN with cmp high: duty cycle and two full windows
    cmp_drv = 1'b1;
    exp_q.push_back(5'd16);
    exp_q.push_back(5'd16);
    run_en = 1'b1;
    t0 = cyc;
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (ota_en) hi++;
    end
    check("run_en_hi", hi, 9);
    step();
    check("run_rewake", ota_en, 1);
    wait_rv(2, 2200);
    if (rv_cyc.size() >= 2) begin
      check("rv_first", rv_cyc[0] - t0, 970);
      check("rv_period", rv_cyc[1] - rv_cyc[0], 1024);
    end
    check("res_hold", res_count, 16);

    // Alternate the comparator every period: half density
    exp_q.push_back(5'd8);
    for (int p = 0; p < 16; p++) begin
      k = 0;
      while (!ota_en && k < 100) begin step(); k++; end
      cmp_drv = ~cmp_drv;
      while (ota_en && k < 100) begin step(); k++; end
    end
    wait_rv(3, 200);
    cmp_drv = 1'b1;
    if (rv_cyc.size() >= 3) check("rv_period2", rv_cyc[2] - rv_cyc[1], 1024);

    // Calibration requested mid-window; serviced at the end of the current sleep
    y = (rv_cyc.size() >= 3) ? rv_cyc[2] : cyc;
    exp_q.push_back(5'd16);
    wait_until(y + 99);
    cal_start = 1'b1;
    wait_until(y + 100);
    cal_start = 1'b0;
    wait_until(y + 118);
    check("pend_sleep_busy", busy, 1);
    check("pend_no_short", ota_short, 0);
    wait_until(y + 119);
    check("pend_idle", busy, 0);
    wait_until(y + 120);
    check("pend_cal_short", ota_short, 1);
    k = 0;
    while (!cal_done && k < 60) begin step(); k++; end
    check("pend_done_cyc", cyc - y, 156);
    check("pend_trim", trim, 0);
    wait_rv(4, 1200);
    if (rv_cyc.size() >= 4) check("pend_rv_cyc", rv_cyc[3] - y, 1126);

    // run_en dropped mid-window: current period completes, no result
    z = (rv_cyc.size() >= 4) ? rv_cyc[3] : cyc;
    wait_until(z + 200);
    run_en = 1'b0;
    wait_until(z + 246);
    check("stop_busy_last", busy, 1);
    wait_until(z + 247);
    check("stop_idle", busy, 0);
    check("stop_ota_en", ota_en, 0);
    wait_until(z + 400);
    check("stop_no_rv", rv_cyc.size(), 4);
    check("stop_res_hold", res_count, 16);

    // ena low during calibration
    cmp_drv = 1'b0;
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    c0 = cyc;
    wait_until(c0 + 10);
    check("ena_trim_pre", trim, 12);
    ena = 1'b0;
    wait_until(c0 + 11);
    check("ena_busy", busy, 0);
    check("ena_ota_en", ota_en, 0);
    check("ena_short", ota_short, 0);
    check("ena_state", dbg_state, 0);
    check("ena_trim", trim, 12);
    check("ena_res_count", res_count, 16);
    ena = 1'b1;
    wait_until(c0 + 13);
    check("ena_stay_idle", busy, 0);

    // Asynchronous reset mid-calibration
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    c0 = cyc;
    wait_until(c0 + 10);
    check("arst_trim_pre", trim, 12);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_trim", trim, 8);
    check("arst_busy", busy, 0);
    check("arst_ota_en", ota_en, 0);
    check("arst_short", ota_short, 0);
    check("arst_res_count", res_count, 0);
    #2;
    rst_n = 1'b1;
    step();
    step();
    check("arst_idle", busy, 0);
    check("arst_trim_hold", trim, 8);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
